// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU logic blocks.
//   - OP_AND / OP_OR / OP_XOR / OP_NAND : 2-bit bitwise opcode encoding
//   - state_t                           : serial unit FSM state encoding
//   - ALU_W                             : default datapath width
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/logic_bit_cell.sv
// logic_bit_cell: one-bit bitwise function y = f(op, a_bit, b_bit).
// Purely combinational; also used by the parallel gates when built bitwise.
// Ports:
//   op    in  2  opcode (AND, OR, XOR, NAND)
//   a_bit in  1  operand A bit
//   b_bit in  1  operand B bit
//   y     out 1  result bit
module logic_bit_cell
  import alu_pkg::*;
(
  input  logic [1:0] op,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic       y
);

  // All four codes are defined, so the default arm is never taken.
  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = a_bit & b_bit;
      OP_OR:   y = a_bit | b_bit;
      OP_XOR:  y = a_bit ^ b_bit;
      OP_NAND: y = ~(a_bit & b_bit);
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bit-serial bitwise logic unit (AND/OR/XOR/NAND).
// Accepts operands, produces one result bit per clock LSB first, then
// presents the full result word with a zero flag.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   in_valid   in   operand/opcode offer
//   in_ready   out  unit can accept operands (IDLE)
//   a, b       in   operands (size bits), sampled only at acceptance
//   op         in   2-bit opcode
//   out_valid  out  result available (DONE)
//   out_ready  in   consumer takes result
//   r          out  result word
//   zero       out  r == 0, valid only while out_valid
//   busy       out  high in RUN or DONE
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready/out_valid are registered and depend only on state;
// the producer may hold or drop valid at will, and valid offered while the
// unit is not ready is simply ignored (no queuing, no error).
module serial_logic_unit
  import alu_pkg::*;
#(
  parameter int size = ALU_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] r,
  output logic            zero,
  output logic            busy
);

  localparam int CNT_W = $clog2(size);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(size - 1);

  // FSM state kept as a named register so checkers can bind to it.
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [size-1:0]   a_q;
  logic [size-1:0]   b_q;
  logic [1:0]        op_q;

  logic              res_bit;
  logic [size-1:0]   r_next;

  logic_bit_cell u_cell (
    .op    (op_q),
    .a_bit (a_q[cnt]),
    .b_bit (b_q[cnt]),
    .y     (res_bit)
  );

  // Right shift with the new bit entering at the MSB: after size shifts the
  // bit produced for index i has travelled down to position i.
  assign r_next = {res_bit, r[size-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      r         <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          r <= r_next;
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            // Flag from the completed word, not the partially shifted one.
            zero      <= (r_next == '0);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit with hand-computed expected results.
module tb_serial_logic_unit;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] r;
  logic         zero;
  logic         busy;

  serial_logic_unit #(.size(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .zero      (zero),
    .busy      (busy)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         expz_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Offers one operation, waits for the result, checks latency and result,
  // optionally stalls out_ready in DONE while pulsing in_valid, and
  // optionally scrambles a/b right after acceptance.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [1:0] top, input int stall, input bit scramble,
                        input logic [W-1:0] er, input bit ez);
    int n;
    logic [W-1:0] held_r;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back(er);
    expz_q.push_back(ez);
    @(negedge clk);                       // accepting edge has passed
    in_valid = 1'b0;
    if (scramble) begin a = 16'hFFFF; b = 16'hFFFF; op = 2'b01; end
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd16);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      check({tag, "_r"}, 32'(r), 32'(exp_q.pop_front()));
      check({tag, "_zero"}, 32'(zero), 32'(expz_q.pop_front()));
    end
    held_r = er;
    for (int k = 0; k < stall; k++) begin
      in_valid = (k % 2 == 0);
      a = 16'h1111; b = 16'h2222;
      @(negedge clk);
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_r"}, 32'(r), 32'(held_r));
      check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);                       // handshake edge has passed
    check({tag, "_valid_pulse"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_zero_cleared"}, 32'(zero), 32'd0);
    check({tag, "_r_held_idle"}, 32'(r), 32'(er));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Same operands through all four opcodes.
    run_op("and", 16'h00F8, 16'h0147, 2'b00, 0, 1'b0, 16'h0040, 1'b0);
    run_op("or",  16'h00F8, 16'h0147, 2'b01, 0, 1'b0, 16'h01FF, 1'b0);
    run_op("xor", 16'h00F8, 16'h0147, 2'b10, 0, 1'b0, 16'h01BF, 1'b0);
    run_op("nand",16'h00F8, 16'h0147, 2'b11, 0, 1'b0, 16'hFFBF, 1'b0);

    // Zero flag set / clear.
    run_op("and_z", 16'hAAAA, 16'h5555, 2'b00, 0, 1'b0, 16'h0000, 1'b1);
    run_op("or_f",  16'hAAAA, 16'h5555, 2'b01, 0, 1'b0, 16'hFFFF, 1'b0);

    // Back-pressure in DONE with ignored in_valid pulses.
    run_op("stall", 16'h0F0F, 16'h00FF, 2'b10, 5, 1'b0, 16'h0FF0, 1'b0);
    @(negedge clk);
    check("stall_no_accept", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; op = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_r", 32'(r), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) check("abandoned_no_valid", 32'(out_valid), 32'd0);
    end
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    run_op("xor_after_rst", 16'h1234, 16'hFFFF, 2'b10, 0, 1'b0, 16'hEDCB, 1'b0);

    // Operands changed right after acceptance must not matter.
    run_op("latched", 16'h00F0, 16'h0F0F, 2'b00, 0, 1'b1, 16'h0000, 1'b1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
- Bit-serial counterpart of the 16-bit parallel bitwise gates in the ALU.
- Accepts two operands and an opcode over a valid/ready handshake, then computes one result bit per clock, LSB first.
- Returns the full result word and a zero flag over a second valid/ready handshake.
- Sits between the operand register file and the ALU result mux, for area-constrained builds.

Parameters:
- size, 16, operand/result width in bits (>= 2)
- CNT_W, $clog2(size), width of the bit counter (derived; not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand/opcode offer
- in_ready  output  1  block can accept operands
- a  input  size  operand A
- b  input  size  operand B
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NAND
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- r  output  size  result word
- zero  output  1  r == 0
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, cnt=0
  - a_q=0, b_q=0, op_q=0
  - r=0, zero=0, out_valid=0, busy=0
  - in_ready=1 once rst deasserts
- States:
  - IDLE: in_ready=1. On in_valid at a rising edge, latch a_q=a, b_q=b, op_q=op, cnt=0, go to RUN.
  - RUN: in_ready=0, busy=1. Each edge computes bit = f(op_q, a_q[cnt], b_q[cnt]).
    - Shift the result register right and insert the bit at the MSB; increment cnt.
    - On the edge where cnt==size-1, go to DONE. After size shifts, bit i of r equals f(a_q[i], b_q[i]).
  - DONE: out_valid=1, r and zero held stable, busy=1, in_ready=0. On out_ready at an edge, go to IDLE and clear out_valid.
- Latency: out_valid rises exactly size clock edges after the accepting edge (16 for the default).
- Throughput: one operation per size+2 cycles minimum.
- in_valid in RUN/DONE is ignored. No queuing and no error.
- a, b and op are sampled only at acceptance. Later changes do not affect the result.
- zero is registered, computed from the final result word, and valid only while out_valid=1. It is 0 otherwise, and r holds its last value.
- r updates only in RUN. In IDLE, r keeps the previous result.
- cnt wraps only via the RUN->DONE transition; it never exceeds size-1.
- Reset mid-operation (RUN or DONE):
  - the operation is abandoned and out_valid is never asserted for it;
  - all registers return to reset values;
  - the first edge after rst deasserts may accept a new operation.
- out_ready held high before DONE completes the handshake on the first DONE cycle, giving out_valid a one-cycle pulse.
- The 2-bit op is fully decoded; no undefined codes.

Decomposition:
- Shared package alu_pkg:
  - op code localparams OP_AND, OP_OR, OP_XOR, OP_NAND;
  - state encoding IDLE/RUN/DONE;
  - default width constant 16.
- One sub-module, logic_bit_cell: combinational 1-bit f(op, a_bit, b_bit). It is reused by the parallel gates when built bitwise.
- FSM, counter, shift register and handshakes stay in serial_logic_unit.

Test Plan:
- AND, a=0x00F8 (248), b=0x0147 (327), out_ready=1 -> out_valid exactly 16 edges after accept, r=0x0040, zero=0, then back to IDLE with in_ready=1.
- Same operands with op=OR/XOR/NAND in sequence -> r=0x01FF, 0x01BF, 0xFFBF; zero=0 each time; three separate out_valid pulses.
- AND a=0xAAAA, b=0x5555 -> r=0x0000, zero=1. Then OR on the same operands -> r=0xFFFF, zero=0.
- out_ready held 0 for 5 cycles in DONE, with in_valid pulsed meanwhile -> out_valid and r stay stable, in_ready=0, the pulses are ignored, and the result is taken when out_ready=1.
- rst asserted asynchronously at cycle 8 of RUN -> out_valid=0, r=0, busy=0 immediately; after release, XOR 0x1234^0xFFFF gives r=0xEDCB after 16 edges.
- a and b changed to 0xFFFF on the cycle after accepting AND 0x00F0,0x0F0F -> r=0x0000, zero=1 (latched operands used).
